// File: rtl/tdm_demux4.sv
// Receiving end of a 4-slot TDM link: locks on frame sync, steers valid beats
// into shadow registers and presents each complete frame on four parallel outputs.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sync,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             out_valid,
    output logic [1:0]       slot,
    output logic             sync_err
);

    localparam logic [0:0] WAIT_SYNC = 1'b0;
    localparam logic [0:0] RUN       = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [WIDTH-1:0] out_c_q, out_c_d, out_d_q, out_d_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q, sync_err_d;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_d_d     = out_d_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        if (in_valid) begin
            if (state_q == WAIT_SYNC) begin
                if (in_sync) begin
                    sh0_d   = in_data;
                    slot_d  = 2'd1;
                    state_d = RUN;
                end
            end else if (in_sync && slot_q != 2'd0) begin
                // Sync mid-frame: drop the partial frame and realign on this beat.
                sync_err_d = 1'b1;
                sh0_d      = in_data;
                slot_d     = 2'd1;
            end else begin
                case (slot_q)
                    2'd0: sh0_d = in_data;
                    2'd1: sh1_d = in_data;
                    2'd2: sh2_d = in_data;
                    default: begin
                        out_a_d     = sh0_q;
                        out_b_d     = sh1_q;
                        out_c_d     = sh2_q;
                        out_d_d     = in_data;
                        out_valid_d = 1'b1;
                    end
                endcase
                slot_d = slot_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_SYNC;
            slot_q      <= 2'd0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_d_q     <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_d_q     <= out_d_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_d     = out_d_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed testbench for tdm_demux4 (WIDTH=1): lock, slot steering, pre-lock
// drop, mid-frame sync recovery, gaps and reset mid-frame.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:0] in_data;
    logic       in_valid;
    logic       in_sync;
    logic [0:0] out_a, out_b, out_c, out_d;
    logic       out_valid;
    logic [1:0] slot;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    tdm_demux4 #(.WIDTH(1)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_sync(in_sync),
        .out_a(out_a),
        .out_b(out_b),
        .out_c(out_c),
        .out_d(out_d),
        .out_valid(out_valid),
        .slot(slot),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] word();
        return {out_a, out_b, out_c, out_d};
    endfunction

    // Drive one cycle of inputs on the falling edge, then settle past the rising edge.
    task automatic step(input logic v, input logic s, input logic d);
        @(negedge clk);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if (word() !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b exp %b", word(), 4'b0000);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_sync_err got %b exp 0", sync_err);
        end
        checks++;
        if (slot !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_slot got %0d exp 0", slot);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lock_frame();
        logic [3:0] f;
        f = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, f[3-i]);
            checks++;
            if (out_valid !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL lock_out_valid beat %0d got %b exp %b", i, out_valid, i == 3);
            end
            checks++;
            if (slot !== 2'((i + 1) % 4)) begin
                errors++;
                $display("[TB] FAIL lock_slot beat %0d got %0d exp %0d", i, slot, (i + 1) % 4);
            end
        end
        checks++;
        if (word() !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL lock_outputs got %b exp %b", word(), 4'b1000);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || word() !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL lock_hold got valid=%b out=%b exp valid=0 out=1000", out_valid, word());
        end
    endtask

    task automatic test_steering();
        logic [3:0] frames [3];
        int err_count;
        frames    = '{4'b0100, 4'b0010, 4'b0001};
        err_count = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b1, f == 0 && i == 0, frames[f][3-i]);
                if (sync_err) err_count++;
                checks++;
                if (out_valid !== (i == 3)) begin
                    errors++;
                    $display("[TB] FAIL steer_out_valid frame %0d beat %0d got %b exp %b", f, i, out_valid, i == 3);
                end
            end
            checks++;
            if (word() !== frames[f]) begin
                errors++;
                $display("[TB] FAIL steer_outputs frame %0d got %b exp %b", f, word(), frames[f]);
            end
        end
        checks++;
        if (err_count !== 0) begin
            errors++;
            $display("[TB] FAIL steer_sync_err got %0d pulses exp 0", err_count);
        end
    endtask

    task automatic test_prelock();
        logic [3:0] f;
        int vcount;
        f      = 4'b1101;
        vcount = 0;
        do_reset(1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1);
            checks++;
            if (slot !== 2'd0 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL prelock_drop beat %0d got slot=%0d valid=%b exp slot=0 valid=0", i, slot, out_valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, f[3-i]);
            if (out_valid) vcount++;
        end
        step(1'b0, 1'b0, 1'b0);
        if (out_valid) vcount++;
        checks++;
        if (word() !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL prelock_outputs got %b exp %b", word(), 4'b1101);
        end
        checks++;
        if (vcount !== 1) begin
            errors++;
            $display("[TB] FAIL prelock_valid_count got %0d exp 1", vcount);
        end
    endtask

    task automatic test_midsync();
        int vcount;
        int ecount;
        vcount = 0;
        ecount = 0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (sync_err !== 1'b1 || out_valid !== 1'b0 || slot !== 2'd1) begin
            errors++;
            $display("[TB] FAIL midsync_pulse got err=%b valid=%b slot=%0d exp err=1 valid=0 slot=1", sync_err, out_valid, slot);
        end
        checks++;
        if (word() !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL midsync_no_partial got %b exp %b", word(), 4'b1101);
        end
        ecount += int'(sync_err);
        vcount += int'(out_valid);
        step(1'b1, 1'b0, 1'b0);
        ecount += int'(sync_err);
        vcount += int'(out_valid);
        step(1'b1, 1'b0, 1'b1);
        ecount += int'(sync_err);
        vcount += int'(out_valid);
        step(1'b1, 1'b0, 1'b0);
        ecount += int'(sync_err);
        vcount += int'(out_valid);
        checks++;
        if (word() !== 4'b1010 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midsync_outputs got out=%b valid=%b exp out=1010 valid=1", word(), out_valid);
        end
        checks++;
        if (ecount !== 1 || vcount !== 1) begin
            errors++;
            $display("[TB] FAIL midsync_counts got err=%0d valid=%0d exp err=1 valid=1", ecount, vcount);
        end
    endtask

    task automatic test_gaps_and_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1);
            checks++;
            if (slot !== 2'd2 || out_valid !== 1'b0 || sync_err !== 1'b0 || word() !== 4'b1010) begin
                errors++;
                $display("[TB] FAIL gap_hold cycle %0d got slot=%0d valid=%b err=%b out=%b exp slot=2 valid=0 err=0 out=1010",
                         i, slot, out_valid, sync_err, word());
            end
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (word() !== 4'b1011 || out_valid !== 1'b1 || slot !== 2'd0) begin
            errors++;
            $display("[TB] FAIL gap_frame got out=%b valid=%b slot=%0d exp out=1011 valid=1 slot=0", word(), out_valid, slot);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (slot !== 2'd2) begin
            errors++;
            $display("[TB] FAIL pre_reset_slot got %0d exp 2", slot);
        end
        do_reset(1);
        checks++;
        if (word() !== 4'b0000 || slot !== 2'd0 || out_valid !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_reset got out=%b slot=%0d valid=%b err=%b exp out=0000 slot=0 valid=0 err=0",
                     word(), slot, out_valid, sync_err);
        end
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (slot !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_wait_sync got slot=%0d exp 0", slot);
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (slot !== 2'd1) begin
            errors++;
            $display("[TB] FAIL relock_slot got %0d exp 1", slot);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = 1'b0;
        test_reset();
        test_lock_frame();
        test_steering();
        test_prelock();
        test_midsync();
        test_gaps_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
